nx_ob_stream_packer: RTL and testbench

Outbound stage that sits directly downstream of the nexus core's control and mesh message streams. It arbitrates between the two 31-bit streams and tags each message with bit 31 (1 = control, 0 = mesh), forming the same {is_ctrl, payload} word that the inbound decoder consumes. It packs two tagged words per 64-bit AXI4-stream beat and frames beats into packets with tlast. A half-filled beat is flushed after a timeout so isolated messages are not stranded.

---
 rtl/nx_packer_pkg.sv | 29 ++
 rtl/nx_rr_arbiter.sv | 62 ++++++
 rtl/nx_ob_stream_packer.sv | 167 ++++++++++++++++
 tb/tb_nx_ob_stream_packer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_packer_pkg.sv
// Shared types and constants for the nexus outbound stream packer.
package nx_packer_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int PAYLOAD_WIDTH = 31;

    localparam logic TAG_CTRL = 1'b1;
    localparam logic TAG_MESH = 1'b0;

    localparam logic [7:0] KEEP_FULL = 8'hFF;
    localparam logic [7:0] KEEP_LOW  = 8'h0F;

    typedef enum logic {
        P_EMPTY = 1'b0,
        P_LOW   = 1'b1
    } pack_state_t;

    typedef enum logic {
        CTRL = 1'b0,
        MESH = 1'b1
    } grant_t;

    // Forms the {is_ctrl, payload} word the inbound decoder expects.
    function automatic logic [WORD_WIDTH-1:0] tag_word(input logic tag,
                                                       input logic [PAYLOAD_WIDTH-1:0] payload);
        return {tag, payload};
    endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Two-way grant between the control and mesh streams.
// NX_PACKER_CTRL_PRIORITY_EN selects strict control priority instead of round-robin.
module nx_rr_arbiter
    import nx_packer_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic i_ctrl_valid,
    input  logic i_mesh_valid,
    input  logic i_accept_ok,
    output logic o_ctrl_ready,
    output logic o_mesh_ready
);

    logic w_ctrl_sel;
    logic w_mesh_sel;

`ifdef NX_PACKER_CTRL_PRIORITY_EN
    // Control wins every tie; history is not needed.
    always_comb begin
        w_ctrl_sel = i_ctrl_valid;
        w_mesh_sel = i_mesh_valid && !i_ctrl_valid;
    end
`else
    grant_t r_last_grant;

    // On a tie the source that did not win last time is granted.
    always_comb begin
        w_ctrl_sel = 1'b0;
        w_mesh_sel = 1'b0;
        if (i_ctrl_valid && i_mesh_valid) begin
            if (r_last_grant == MESH) begin
                w_ctrl_sel = 1'b1;
            end else begin
                w_mesh_sel = 1'b1;
            end
        end else if (i_ctrl_valid) begin
            w_ctrl_sel = 1'b1;
        end else if (i_mesh_valid) begin
            w_mesh_sel = 1'b1;
        end else begin
            w_ctrl_sel = 1'b0;
            w_mesh_sel = 1'b0;
        end
    end

    // Grant history, updated on every accepted message.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_grant <= MESH;
        end else if (o_ctrl_ready) begin
            r_last_grant <= CTRL;
        end else if (o_mesh_ready) begin
            r_last_grant <= MESH;
        end
    end
`endif

    assign o_ctrl_ready = w_ctrl_sel && i_accept_ok;
    assign o_mesh_ready = w_mesh_sel && i_accept_ok;

endmodule

// File: rtl/nx_ob_stream_packer.sv
// Packs tagged control/mesh messages two per 64-bit AXI4-stream beat, with packet framing
// and timeout flush of half-filled beats. Option: NX_PACKER_CTRL_PRIORITY_EN (strict priority).
module nx_ob_stream_packer
    import nx_packer_pkg::*;
#(
    parameter int AXI4_DATA_WIDTH = 64,
    parameter int AXI4_STRB_WIDTH = AXI4_DATA_WIDTH / 8,
    parameter int AXI4_ID_WIDTH   = 1,
    parameter int FLUSH_CYCLES    = 16,
    parameter int PKT_BEATS       = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [30:0]                ctrl_ob_data_i,
    input  logic                       ctrl_ob_valid_i,
    output logic                       ctrl_ob_ready_o,
    input  logic [30:0]                mesh_ob_data_i,
    input  logic                       mesh_ob_valid_i,
    output logic                       mesh_ob_ready_o,
    output logic [AXI4_DATA_WIDTH-1:0] outbound_tdata,
    output logic [AXI4_STRB_WIDTH-1:0] outbound_tkeep,
    output logic [AXI4_STRB_WIDTH-1:0] outbound_tstrb,
    output logic [AXI4_ID_WIDTH-1:0]   outbound_tid,
    output logic                       outbound_tlast,
    output logic                       outbound_tvalid,
    input  logic                       outbound_tready
);

    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
    localparam logic [7:0] BEAT_LAST  = 8'(PKT_BEATS - 1);

    pack_state_t            r_state;
    pack_state_t            w_state_nxt;
    logic [WORD_WIDTH-1:0]  r_low_word;
    logic [7:0]             r_flush_cnt;
    logic [7:0]             r_beat_cnt;
    logic [7:0]             w_beat_cnt_nxt;
    logic [63:0]            r_tdata;
    logic [7:0]             r_tkeep;
    logic                   r_tlast;
    logic                   r_tvalid;

    logic                   w_out_free;
    logic                   w_accept_ok;
    logic                   w_ctrl_ready;
    logic                   w_mesh_ready;
    logic                   w_accept;
    logic                   w_handshake;
    logic                   w_load_full;
    logic                   w_load_flush;
    logic                   w_full_last;
    logic [WORD_WIDTH-1:0]  w_new_word;

    assign w_out_free  = !r_tvalid || outbound_tready;
    assign w_accept_ok = (r_state == P_EMPTY) || w_out_free;
    assign w_accept    = w_ctrl_ready || w_mesh_ready;
    assign w_handshake = r_tvalid && outbound_tready;
    assign w_new_word  = w_ctrl_ready ? tag_word(TAG_CTRL, ctrl_ob_data_i)
                                      : tag_word(TAG_MESH, mesh_ob_data_i);

    nx_rr_arbiter u_arb (
        .clk          (clk),
        .rstn         (rstn),
        .i_ctrl_valid (ctrl_ob_valid_i),
        .i_mesh_valid (mesh_ob_valid_i),
        .i_accept_ok  (w_accept_ok),
        .o_ctrl_ready (w_ctrl_ready),
        .o_mesh_ready (w_mesh_ready)
    );

    // Pack FSM: an accept in P_LOW always beats a pending flush.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_full  = 1'b0;
        w_load_flush = 1'b0;
        case (r_state)
            P_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = P_LOW;
                end else begin
                    w_state_nxt = P_EMPTY;
                end
            end
            P_LOW: begin
                if (w_accept) begin
                    w_load_full = 1'b1;
                    w_state_nxt = P_EMPTY;
                end else if ((r_flush_cnt == FLUSH_LAST) && w_out_free) begin
                    w_load_flush = 1'b1;
                    w_state_nxt  = P_EMPTY;
                end else begin
                    w_state_nxt = P_LOW;
                end
            end
            default: begin
                w_state_nxt = P_EMPTY;
            end
        endcase
    end

    // The beat being loaded is numbered after the one leaving this cycle.
    always_comb begin
        w_beat_cnt_nxt = r_beat_cnt;
        if (w_handshake) begin
            if (r_tlast) begin
                w_beat_cnt_nxt = 8'd0;
            end else begin
                w_beat_cnt_nxt = r_beat_cnt + 8'd1;
            end
        end else begin
            w_beat_cnt_nxt = r_beat_cnt;
        end
    end

    assign w_full_last = (w_beat_cnt_nxt == BEAT_LAST);

    // Pack state, held lower word and idle/beat counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= P_EMPTY;
            r_low_word  <= 32'h0;
            r_flush_cnt <= 8'd0;
            r_beat_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            if ((r_state == P_EMPTY) && w_accept) begin
                r_low_word  <= w_new_word;
                r_flush_cnt <= 8'd0;
            end else if ((r_state == P_LOW) && !w_accept && (r_flush_cnt != FLUSH_LAST)) begin
                r_flush_cnt <= r_flush_cnt + 8'd1;
            end
        end
    end

    // Output register: loads only when free, so a stalled beat is never disturbed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tdata  <= 64'h0;
            r_tkeep  <= 8'h00;
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
        end else if (w_load_full) begin
            r_tdata  <= {w_new_word, r_low_word};
            r_tkeep  <= KEEP_FULL;
            r_tlast  <= w_full_last;
            r_tvalid <= 1'b1;
        end else if (w_load_flush) begin
            r_tdata  <= {32'h0, r_low_word};
            r_tkeep  <= KEEP_LOW;
            r_tlast  <= 1'b1;
            r_tvalid <= 1'b1;
        end else if (w_handshake) begin
            r_tvalid <= 1'b0;
        end
    end

    assign ctrl_ob_ready_o = w_ctrl_ready;
    assign mesh_ob_ready_o = w_mesh_ready;
    assign outbound_tdata  = r_tdata;
    assign outbound_tkeep  = r_tkeep;
    assign outbound_tstrb  = r_tkeep;
    assign outbound_tlast  = r_tlast;
    assign outbound_tvalid = r_tvalid;
    assign outbound_tid    = {AXI4_ID_WIDTH{1'b0}};

endmodule

// File: tb/tb_nx_ob_stream_packer.sv
// Self-checking bench for nx_ob_stream_packer: directed scenarios plus randomized traffic
// scored against a word-queue model of the packing and framing rules.
module tb_nx_ob_stream_packer;

    localparam int FLUSH = 16;
    localparam int PKT   = 8;

    logic        clk;
    logic        rstn;
    logic [30:0] ctrl_ob_data_i;
    logic        ctrl_ob_valid_i;
    logic        ctrl_ob_ready_o;
    logic [30:0] mesh_ob_data_i;
    logic        mesh_ob_valid_i;
    logic        mesh_ob_ready_o;
    logic [63:0] outbound_tdata;
    logic [7:0]  outbound_tkeep;
    logic [7:0]  outbound_tstrb;
    logic [0:0]  outbound_tid;
    logic        outbound_tlast;
    logic        outbound_tvalid;
    logic        outbound_tready;

    nx_ob_stream_packer #(.FLUSH_CYCLES(FLUSH), .PKT_BEATS(PKT)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ctrl_ob_data_i  (ctrl_ob_data_i),
        .ctrl_ob_valid_i (ctrl_ob_valid_i),
        .ctrl_ob_ready_o (ctrl_ob_ready_o),
        .mesh_ob_data_i  (mesh_ob_data_i),
        .mesh_ob_valid_i (mesh_ob_valid_i),
        .mesh_ob_ready_o (mesh_ob_ready_o),
        .outbound_tdata  (outbound_tdata),
        .outbound_tkeep  (outbound_tkeep),
        .outbound_tstrb  (outbound_tstrb),
        .outbound_tid    (outbound_tid),
        .outbound_tlast  (outbound_tlast),
        .outbound_tvalid (outbound_tvalid),
        .outbound_tready (outbound_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    logic [31:0] q[$];
    int          m_beat;
    logic        m_last;
    int          n_acc;
    int          n_hs;
    logic        acc_log[$];
    logic        tl_log[$];
    logic [63:0] td_log[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Score a completed beat against the accepted-word queue and packet position.
    task automatic score_beat(input logic [63:0] td, input logic [7:0] tk, input logic [7:0] ts,
                              input logic tl);
        logic el;
        n_hs++;
        tl_log.push_back(tl);
        td_log.push_back(td);
        chk("tstrb_eq_tkeep", ts, tk);
        if (tk == 8'hFF) begin
            chk("full_beat_words", q.size() >= 2, 1'b1);
            if (q.size() >= 2) begin
                chk("beat_data", td, {q[1], q[0]});
                el = (m_beat == PKT - 1);
                chk("beat_tlast", tl, el);
                void'(q.pop_front());
                void'(q.pop_front());
                m_beat = el ? 0 : m_beat + 1;
            end
        end else begin
            chk("beat_keep", tk, 8'h0F);
            chk("flush_beat_words", q.size() >= 1, 1'b1);
            if (q.size() >= 1) begin
                chk("flush_data", td, {32'h0, q[0]});
                chk("flush_tlast", tl, 1'b1);
                void'(q.pop_front());
            end
            m_beat = 0;
        end
    endtask

    // One clock: sample before the edge, advance to the next negedge, update the model.
    task automatic cycle();
        logic cv, cr, mv, mr, tv, tr, tl, gc, gm, any;
        logic [30:0] cd, md;
        logic [63:0] td;
        logic [7:0]  tk, ts;
        #1;
        cv = ctrl_ob_valid_i; cr = ctrl_ob_ready_o; cd = ctrl_ob_data_i;
        mv = mesh_ob_valid_i; mr = mesh_ob_ready_o; md = mesh_ob_data_i;
        tv = outbound_tvalid; tr = outbound_tready; td = outbound_tdata;
        tk = outbound_tkeep;  ts = outbound_tstrb;  tl = outbound_tlast;
`ifdef NX_PACKER_CTRL_PRIORITY_EN
        gc = cv;
`else
        gc = cv && (!mv || m_last == 1'b1);
`endif
        gm = mv && !gc;
        any = cr | mr;
        chk("ctrl_grant", cr, gc & any);
        chk("mesh_grant", mr, gm & any);
        @(posedge clk);
        @(negedge clk);
        if (tv && tr) score_beat(td, tk, ts, tl);
        if (cv && cr) begin
            q.push_back({1'b1, cd}); m_last = 1'b0; acc_log.push_back(1'b0); n_acc++;
        end else if (mv && mr) begin
            q.push_back({1'b0, md}); m_last = 1'b1; acc_log.push_back(1'b1); n_acc++;
        end
        if (tv && !tr) begin
            chk("hold_tvalid", outbound_tvalid, 1'b1);
            chk("hold_tdata", outbound_tdata, td);
            chk("hold_tkeep", outbound_tkeep, tk);
            chk("hold_tlast", outbound_tlast, tl);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int base, hbase, lat, guard;
        logic [63:0] td0;
        logic [7:0]  tk0;
        logic        tl0;
        logic [30:0] a, b;
        checks = 0; failures = 0; m_beat = 0; m_last = 1'b1; n_acc = 0; n_hs = 0;
        rstn = 1'b0; outbound_tready = 1'b0;
        ctrl_ob_valid_i = 1'b0; mesh_ob_valid_i = 1'b0;
        ctrl_ob_data_i = 31'h0; mesh_ob_data_i = 31'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", outbound_tvalid, 1'b0);
        chk("rst_tdata", outbound_tdata, 64'h0);
        chk("rst_tkeep", outbound_tkeep, 8'h00);
        chk("rst_tstrb", outbound_tstrb, 8'h00);
        chk("rst_tlast", outbound_tlast, 1'b0);
        chk("rst_tid", outbound_tid, 1'b0);
        rstn = 1'b1;

        // Two messages form one full beat, visible right after the second accept.
        outbound_tready = 1'b1;
        ctrl_ob_valid_i = 1'b1; ctrl_ob_data_i = 31'h0000_0001;
        cycle();
        chk("t1_first_acc", n_acc, 1);
        ctrl_ob_valid_i = 1'b0;
        mesh_ob_valid_i = 1'b1; mesh_ob_data_i = 31'h0000_0002;
        chk("t1_tvalid_early", outbound_tvalid, 1'b0);
        cycle();
        mesh_ob_valid_i = 1'b0;
        chk("t1_tvalid", outbound_tvalid, 1'b1);
        chk("t1_tdata", outbound_tdata, 64'h0000_0002_8000_0001);
        chk("t1_tkeep", outbound_tkeep, 8'hFF);
        chk("t1_tlast", outbound_tlast, 1'b0);
        cycle();

        // Lone message is flushed after the idle timeout.
        mesh_ob_valid_i = 1'b1; mesh_ob_data_i = 31'h7FFF_FFFF;
        base = n_acc;
        cycle();
        mesh_ob_valid_i = 1'b0;
        chk("t2_acc", n_acc - base, 1);
        lat = 0;
        while (outbound_tvalid !== 1'b1 && lat < 100) begin
            cycle();
            lat++;
        end
        chk("t2_latency", lat, FLUSH);
        chk("t2_tdata", outbound_tdata, 64'h0000_0000_7FFF_FFFF);
        chk("t2_tkeep", outbound_tkeep, 8'h0F);
        chk("t2_tlast", outbound_tlast, 1'b1);
        cycle();

        // 16 back-to-back pairs: tlast only on beats 8 and 16.
        base = n_acc; hbase = n_hs; guard = 0;
        ctrl_ob_valid_i = 1'b1; mesh_ob_valid_i = 1'b1;
        while (n_acc - base < 32 && guard < 100) begin
            ctrl_ob_data_i = 31'($urandom); mesh_ob_data_i = 31'($urandom);
            cycle();
            guard++;
        end
        ctrl_ob_valid_i = 1'b0; mesh_ob_valid_i = 1'b0;
        repeat (3) cycle();
        chk("t4_accepts", n_acc - base, 32);
        chk("t4_cycles", guard, 32);
        chk("t4_beats", n_hs - hbase, 16);
        if (n_hs - hbase == 16) begin
            for (int i = 0; i < 16; i++) chk("t4_tlast_pos", tl_log[hbase + i], (i == 7 || i == 15));
        end

        // Continuous contention: grant order and beat composition.
        base = n_acc; hbase = n_hs;
        ctrl_ob_valid_i = 1'b1; mesh_ob_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ctrl_ob_data_i = 31'($urandom); mesh_ob_data_i = 31'($urandom);
            cycle();
        end
        ctrl_ob_valid_i = 1'b0; mesh_ob_valid_i = 1'b0;
        repeat (2) cycle();
        chk("t3_accepts", n_acc - base, 8);
        chk("t3_beats", n_hs - hbase, 4);
        for (int i = 0; i < 8 && base + i < n_acc; i++) begin
`ifdef NX_PACKER_CTRL_PRIORITY_EN
            chk("t3_grant", acc_log[base + i], 1'b0);
`else
            chk("t3_grant", acc_log[base + i], (i % 2) == 1);
`endif
        end
        for (int i = hbase; i < n_hs; i++) begin
`ifdef NX_PACKER_CTRL_PRIORITY_EN
            chk("t3_upper_tag", td_log[i][63], 1'b1);
`else
            chk("t3_upper_tag", td_log[i][63], 1'b0);
`endif
            chk("t3_lower_tag", td_log[i][31], 1'b1);
        end

        // Backpressure: one extra message held, then all readies drop.
        outbound_tready = 1'b0;
        base = n_acc;
        ctrl_ob_valid_i = 1'b1; ctrl_ob_data_i = 31'($urandom);
        cycle();
        ctrl_ob_valid_i = 1'b0;
        mesh_ob_valid_i = 1'b1; mesh_ob_data_i = 31'($urandom);
        cycle();
        chk("t5_pair_acc", n_acc - base, 2);
        chk("t5_pending", outbound_tvalid, 1'b1);
        td0 = outbound_tdata; tk0 = outbound_tkeep; tl0 = outbound_tlast;
        ctrl_ob_valid_i = 1'b1;
        base = n_acc;
        for (int i = 0; i < 10; i++) begin
            ctrl_ob_data_i = 31'($urandom); mesh_ob_data_i = 31'($urandom);
            cycle();
            chk("t5_tvalid", outbound_tvalid, 1'b1);
            chk("t5_tdata", outbound_tdata, td0);
            chk("t5_tkeep", outbound_tkeep, tk0);
            chk("t5_tlast", outbound_tlast, tl0);
        end
        chk("t5_extra_acc", n_acc - base, 1);
        #1;
        chk("t5_ctrl_ready_low", ctrl_ob_ready_o, 1'b0);
        chk("t5_mesh_ready_low", mesh_ob_ready_o, 1'b0);
        ctrl_ob_valid_i = 1'b0; mesh_ob_valid_i = 1'b0;
        outbound_tready = 1'b1;
        repeat (25) cycle();
        chk("t5_no_loss", q.size(), 0);
        chk("t5_drained", outbound_tvalid, 1'b0);

        // Reset with a pending beat and a held half-word.
        outbound_tready = 1'b0;
        ctrl_ob_valid_i = 1'b1; ctrl_ob_data_i = 31'($urandom);
        cycle();
        ctrl_ob_valid_i = 1'b0;
        mesh_ob_valid_i = 1'b1; mesh_ob_data_i = 31'($urandom);
        cycle();
        mesh_ob_valid_i = 1'b0;
        ctrl_ob_valid_i = 1'b1; ctrl_ob_data_i = 31'($urandom);
        cycle();
        ctrl_ob_valid_i = 1'b0;
        chk("t6_pending", outbound_tvalid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("t6_tvalid_async", outbound_tvalid, 1'b0);
        chk("t6_tkeep_async", outbound_tkeep, 8'h00);
        q.delete(); m_beat = 0; m_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        outbound_tready = 1'b1;
        a = 31'($urandom); b = 31'($urandom);
        ctrl_ob_valid_i = 1'b1; ctrl_ob_data_i = a;
        cycle();
        ctrl_ob_valid_i = 1'b0;
        mesh_ob_valid_i = 1'b1; mesh_ob_data_i = b;
        cycle();
        mesh_ob_valid_i = 1'b0;
        chk("t6_post_tvalid", outbound_tvalid, 1'b1);
        chk("t6_post_tdata", outbound_tdata, {1'b0, b, 1'b1, a});
        cycle();

        // Random traffic and backpressure, scored by the queue model.
        for (int i = 0; i < 400; i++) begin
            ctrl_ob_valid_i = ($urandom_range(0, 99) < 55);
            mesh_ob_valid_i = ($urandom_range(0, 99) < 55);
            ctrl_ob_data_i  = 31'($urandom);
            mesh_ob_data_i  = 31'($urandom);
            outbound_tready = ($urandom_range(0, 99) < 70);
            cycle();
        end
        ctrl_ob_valid_i = 1'b0; mesh_ob_valid_i = 1'b0;
        outbound_tready = 1'b1;
        repeat (FLUSH + 10) cycle();
        chk("final_no_loss", q.size(), 0);
        chk("final_idle", outbound_tvalid, 1'b0);
        chk("final_tid", outbound_tid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
